fd_de_pipeline_regs: RTL
========================

# fd_de_pipeline_regs

Front-end pipeline register bank for the 5-stage RV32I core. It holds the PC register (F), the F/D register and the D/E register, and is the block that acts on the hazard unit's StallF/StallD/FlushD/FlushE outputs. It also produces the hazard unit's inputs: Rs1D, Rs2D, Rs1E, Rs2E, RdE and ResultSrcE0. Two saturating performance counters, for stall cycles and flush events, sit alongside the registers.

## Interface
Parameters:
- XLEN, 32: datapath width.
- RESET_PC, 32'h0000_0000: PCF value after reset.
- CTRL_W, 10: width of the packed decode-control vector (bit map in package).
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- StallF, StallD, FlushD, FlushE  in  1 each  from hazard control.
- PCSrcE  in  1  redirect taken in E.
- PCTargetE  in  XLEN  redirect target.
- InstrF  in  32  instruction memory read data at PCF.
- CtrlD  in  CTRL_W  control decoder output for InstrD.
- RD1D, RD2D, ImmExtD  in  XLEN each  register file and immediate outputs.
- PCF  out  XLEN  fetch address.
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  F/D contents.
- Rs1D, Rs2D, RdD  out  5 each  taken from InstrD[19:15], [24:20], [11:7].
- CtrlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  D/E contents.
- Rs1E, Rs2E, RdE  out  5 each.
- ResultSrcE0  out  1  CtrlE[RESULTSRC0_BIT].
- ValidD, ValidE  out  1 each  stage holds a real instruction (0 = bubble).
- stall_cnt, flush_cnt  out  CNT_W each.

## Operation
- PC register:
  - If StallF=0: PCF <= PCSrcE ? {PCTargetE[XLEN-1:2],2'b00} : PCF+4.
  - If StallF=1: PCF holds.
  - PCSrcE is ignored while StallF=1, because hazard control never asserts both.
- F/D register, applied in priority order:
  - FlushD=1: load InstrD=NOP (32'h0000_0013), PCD=0, PCPlus4D=0, ValidD=0.
  - Else StallD=1: hold all fields.
  - Else: load InstrF, PCF, PCF+4, ValidD=1.
- D/E register:
  - FlushE=1: CtrlE=0, Rs1E=Rs2E=RdE=0, data fields 0, ValidE=0. This is the bubble, and a zero control vector writes nothing.
  - Else: load the D-stage values and ValidE=ValidD.
  - There is no stall input on D/E.
- Rs1D/Rs2D/RdD are combinational slices of InstrD, so a NOP yields 0/0/0.
- ResultSrcE0 is a combinational bit of CtrlE.
- stall_cnt increments on each cycle with StallD=1 and FlushD=0. It saturates at all-ones.
- flush_cnt increments on each cycle with FlushE=1 or FlushD=1, counting once even if both are asserted. It saturates at all-ones.
- No state machine; every stage is an enable/clear register with the priority above.

## Timing
- Reset (rst_n=0 at an edge):
  - PCF=RESET_PC.
  - InstrD=NOP; all other D/E, Valid and counter outputs are 0.
  - Reset overrides stall and flush.
  - Deasserting mid-stream restarts fetch at RESET_PC on the next edge.
- Latency: InstrF is visible on InstrD one edge after its PCF is presented, and on E outputs one edge later.
- Load-use: StallF=StallD=FlushE=1 for one cycle.
  - PCF and F/D hold.
  - E receives a bubble.
  - The next cycle, the held instruction advances.
- Branch taken: PCSrcE=FlushD=FlushE=1 in the same cycle.
  - PCF loads the target.
  - Both D and E become bubbles.
  - The target instruction reaches D after 1 more edge.
- PC arithmetic wraps modulo 2^XLEN; 32'hFFFF_FFFC+4 gives 0.

## Structure
- Package pipe_pkg holds:
  - NOP_INSTR.
  - CTRL_W and the control bit indices: REGWRITE_BIT, RESULTSRC0_BIT, RESULTSRC1_BIT, MEMWRITE_BIT, JUMP_BIT, BRANCH_BIT, ALUCTRL_LSB/MSB, ALUSRC_BIT.
- One sub-module, pipe_reg:
  - Parameters: width and clear value.
  - Inputs: en, clr.
  - clr has priority over en.
  - Instantiated for PC, F/D and D/E.

## Test plan
- Reset: rst_n=0 for 2 cycles, then 1 with no hazards → PCF=0,4,8 on successive edges; InstrD=NOP and ValidD=0 until the first fetch lands.
- Load-use stall: InstrF=lw x5,0(x1) then add x6,x5,x2; pulse StallF/StallD/FlushE for 1 cycle → PCF holds; RdE=0 and ValidE=0 for one cycle; add reaches E with Rs1E=5; stall_cnt=1.
- Branch flush: PCSrcE=1, PCTargetE=32'h100, FlushD=FlushE=1 → PCF=32'h100 next edge; InstrD=32'h13; CtrlE=0; flush_cnt=1.
- Misaligned target: PCTargetE=32'h103 → PCF=32'h100.
- Priority: StallD=FlushD=1 together → D loads NOP; stall_cnt unchanged.
- Saturation and wrap: CNT_W=4 with 20 stall cycles → stall_cnt=15; RESET_PC=32'hFFFF_FFFC → PCF wraps to 0.

Source files
------------

// File: rtl/fd_de_pipeline_regs_pkg.sv
// Shared constants for the front-end pipeline registers: NOP encoding, decode-control
// bit map and the register-specifier slicing used by the hazard unit.
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

   localparam int CTRL_W         = 10;
   localparam int REGWRITE_BIT   = 0;
   localparam int RESULTSRC0_BIT = 1;
   localparam int RESULTSRC1_BIT = 2;
   localparam int MEMWRITE_BIT   = 3;
   localparam int JUMP_BIT       = 4;
   localparam int BRANCH_BIT     = 5;
   localparam int ALUCTRL_LSB    = 6;
   localparam int ALUCTRL_MSB    = 8;
   localparam int ALUSRC_BIT     = 9;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } regsel_t;

   // All RV32I formats place rs1/rs2/rd at fixed positions, so slicing is format-agnostic.
   function automatic regsel_t decode_regs(input logic [31:0] instr);
      regsel_t r;
      r.rs1 = instr[19:15];
      r.rs2 = instr[24:20];
      r.rd  = instr[11:7];
      return r;
   endfunction

endpackage

// File: rtl/fd_de_pipeline_regs_if.sv
// Bundle between the front-end register bank and the rest of the core (hazard unit,
// instruction memory, decoder, register file and the E stage consumers).
interface fd_de_pipeline_regs_if #(
   parameter int XLEN   = 32,
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int CNT_W  = 32
);
   logic              StallF;
   logic              StallD;
   logic              FlushD;
   logic              FlushE;
   logic              PCSrcE;
   logic [XLEN-1:0]   PCTargetE;
   logic [31:0]       InstrF;
   logic [CTRL_W-1:0] CtrlD;
   logic [XLEN-1:0]   RD1D;
   logic [XLEN-1:0]   RD2D;
   logic [XLEN-1:0]   ImmExtD;

   logic [XLEN-1:0]   PCF;
   logic [31:0]       InstrD;
   logic [XLEN-1:0]   PCD;
   logic [XLEN-1:0]   PCPlus4D;
   logic [4:0]        Rs1D;
   logic [4:0]        Rs2D;
   logic [4:0]        RdD;
   logic [CTRL_W-1:0] CtrlE;
   logic [XLEN-1:0]   RD1E;
   logic [XLEN-1:0]   RD2E;
   logic [XLEN-1:0]   ImmExtE;
   logic [XLEN-1:0]   PCE;
   logic [XLEN-1:0]   PCPlus4E;
   logic [4:0]        Rs1E;
   logic [4:0]        Rs2E;
   logic [4:0]        RdE;
   logic              ResultSrcE0;
   logic              ValidD;
   logic              ValidE;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  flush_cnt;

   modport master (
      output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF, CtrlD,
             RD1D, RD2D, ImmExtD,
      input  PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, CtrlE, RD1E, RD2E, ImmExtE,
             PCE, PCPlus4E, Rs1E, Rs2E, RdE, ResultSrcE0, ValidD, ValidE,
             stall_cnt, flush_cnt
   );

   modport slave (
      input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF, CtrlD,
             RD1D, RD2D, ImmExtD,
      output PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, CtrlE, RD1E, RD2E, ImmExtE,
             PCE, PCPlus4E, Rs1E, Rs2E, RdE, ResultSrcE0, ValidD, ValidE,
             stall_cnt, flush_cnt
   );

endinterface

// File: rtl/fd_de_pipeline_regs_reg.sv
// Generic pipeline register: synchronous reset and clear both load CLR_VAL, clear
// wins over enable.
module pipe_reg #(
   parameter int           W       = 32,
   parameter logic [W-1:0] CLR_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         clr_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   // NOTE: clocked state uses non-blocking assignment so every register samples
   // pre-edge values, independent of always_ff evaluation order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= CLR_VAL;
      end else if (clr_i) begin
         q_q <= CLR_VAL;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fd_de_pipeline_regs.sv
// Front-end register bank of the 5-stage RV32I core: PC, F/D and D/E registers acting
// on hazard stall/flush controls, plus saturating stall and flush event counters.
module fd_de_pipeline_regs
   import pipe_pkg::NOP_INSTR, pipe_pkg::RESULTSRC0_BIT, pipe_pkg::regsel_t,
          pipe_pkg::decode_regs;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              CTRL_W   = pipe_pkg::CTRL_W,
   parameter int              CNT_W    = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   fd_de_pipeline_regs_if.slave bus
);

   localparam int REGSEL_W = $bits(regsel_t);
   localparam int FD_W     = 1 + 32 + 2 * XLEN;
   localparam int DE_W     = 1 + CTRL_W + REGSEL_W + 5 * XLEN;

   localparam logic [FD_W-1:0] FD_CLR = {1'b0, NOP_INSTR, {(2 * XLEN){1'b0}}};

   // ---------------- PC register ----------------
   logic [XLEN-1:0] pcf_q;
   logic [XLEN-1:0] pcf_d;
   logic [XLEN-1:0] pc_plus4_f;
   logic [XLEN-1:0] target_aligned;

   assign pc_plus4_f     = pcf_q + XLEN'(4);
   assign target_aligned = bus.PCTargetE & ~XLEN'(3);
   assign pcf_d          = bus.PCSrcE ? target_aligned : pc_plus4_f;

   pipe_reg #(.W(XLEN), .CLR_VAL(RESET_PC)) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (!bus.StallF),
      .clr_i (1'b0),
      .d_i   (pcf_d),
      .q_o   (pcf_q)
   );

   // ---------------- F/D register ----------------
   logic [FD_W-1:0] fd_d;
   logic [FD_W-1:0] fd_q;
   logic            valid_d;
   logic [31:0]     instr_d;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_plus4_d;
   regsel_t         regs_d;

   assign fd_d = {1'b1, bus.InstrF, pcf_q, pc_plus4_f};

   pipe_reg #(.W(FD_W), .CLR_VAL(FD_CLR)) u_fd_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (!bus.StallD),
      .clr_i (bus.FlushD),
      .d_i   (fd_d),
      .q_o   (fd_q)
   );

   assign {valid_d, instr_d, pc_d, pc_plus4_d} = fd_q;
   assign regs_d = decode_regs(instr_d);

   // ---------------- D/E register ----------------
   logic [DE_W-1:0]   de_d;
   logic [DE_W-1:0]   de_q;
   logic              valid_e;
   logic [CTRL_W-1:0] ctrl_e;
   regsel_t           regs_e;
   logic [XLEN-1:0]   rd1_e;
   logic [XLEN-1:0]   rd2_e;
   logic [XLEN-1:0]   imm_e;
   logic [XLEN-1:0]   pc_e;
   logic [XLEN-1:0]   pc_plus4_e;

   assign de_d = {valid_d, bus.CtrlD, regs_d, bus.RD1D, bus.RD2D, bus.ImmExtD,
                  pc_d, pc_plus4_d};

   // Always enabled: a load-use stall is realised by flushing E, not holding it.
   pipe_reg #(.W(DE_W), .CLR_VAL('0)) u_de_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (1'b1),
      .clr_i (bus.FlushE),
      .d_i   (de_d),
      .q_o   (de_q)
   );

   assign {valid_e, ctrl_e, regs_e, rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e} = de_q;

   // ---------------- Performance counters ----------------
   logic             stall_event;
   logic             flush_event;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d;

   // A stall overridden by FlushD is not a stall cycle; a double flush counts once.
   assign stall_event = bus.StallD && !bus.FlushD;
   assign flush_event = bus.FlushD || bus.FlushE;

   always_comb begin
      // NOTE: defaults first so every path assigns each output; otherwise a latch is inferred.
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_event && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_event && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // ---------------- Outputs ----------------
   assign bus.PCF         = pcf_q;
   assign bus.InstrD      = instr_d;
   assign bus.PCD         = pc_d;
   assign bus.PCPlus4D    = pc_plus4_d;
   assign bus.ValidD      = valid_d;
   assign bus.Rs1D        = regs_d.rs1;
   assign bus.Rs2D        = regs_d.rs2;
   assign bus.RdD         = regs_d.rd;
   assign bus.CtrlE       = ctrl_e;
   assign bus.RD1E        = rd1_e;
   assign bus.RD2E        = rd2_e;
   assign bus.ImmExtE     = imm_e;
   assign bus.PCE         = pc_e;
   assign bus.PCPlus4E    = pc_plus4_e;
   assign bus.Rs1E        = regs_e.rs1;
   assign bus.Rs2E        = regs_e.rs2;
   assign bus.RdE         = regs_e.rd;
   assign bus.ResultSrcE0 = ctrl_e[RESULTSRC0_BIT];
   assign bus.ValidE      = valid_e;
   assign bus.stall_cnt   = stall_cnt_q;
   assign bus.flush_cnt   = flush_cnt_q;

endmodule
